// File: rtl/isa_video_busif_if.sv
// ISA pin, register-strobe and VRAM-handshake bundle for isa_video_busif.
// slave is the bus interface block itself; master is the host/core side.
interface isa_video_busif_if #(
  parameter int IO_SPAN_LOG2 = 4,
  parameter int FB_SIZE_LOG2 = 15
);
  logic [19:0]             bus_a;
  logic                    bus_ior_l;
  logic                    bus_iow_l;
  logic                    bus_memr_l;
  logic                    bus_memw_l;
  logic                    bus_aen;
  logic [7:0]              bus_d;
  logic [7:0]              bus_out;
  logic                    bus_dir;
  logic                    bus_rdy;
  logic [IO_SPAN_LOG2-1:0] io_reg;
  logic                    io_wr_stb;
  logic                    io_rd_stb;
  logic [7:0]              io_wdata;
  logic [7:0]              io_rdata;
  logic                    mem_req;
  logic                    mem_we;
  logic [FB_SIZE_LOG2-1:0] mem_addr;
  logic [7:0]              mem_wdata;
  logic [7:0]              mem_rdata;
  logic                    mem_ack;
  logic                    timeout_flag;

  modport slave (
    input  bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen, bus_d,
    input  io_rdata, mem_rdata, mem_ack,
    output bus_out, bus_dir, bus_rdy, io_reg, io_wr_stb, io_rd_stb, io_wdata,
    output mem_req, mem_we, mem_addr, mem_wdata, timeout_flag
  );

  modport master (
    output bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen, bus_d,
    output io_rdata, mem_rdata, mem_ack,
    input  bus_out, bus_dir, bus_rdy, io_reg, io_wr_stb, io_rd_stb, io_wdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, timeout_flag
  );
endinterface

// File: rtl/isa_video_busif.sv
// ISA front end for video cards: IO window register strobes and framebuffer VRAM handshake.
// Define BUS_WAIT_STATE_EN to drive IOCHRDY wait states; otherwise bus_rdy is tied high.
module isa_video_busif #(
  parameter logic [19:0] IO_BASE_ADDR = 20'h3D0,
  parameter int          IO_SPAN_LOG2 = 4,
  parameter logic [19:0] FB_ADDR      = 20'hB8000,
  parameter int          FB_SIZE_LOG2 = 15,
  parameter int          MIN_WAIT     = 3,
  parameter int          ACK_TIMEOUT  = 255
) (
  input logic             clk,
  input logic             reset_l,
  isa_video_busif_if.slave bus
);

`ifdef BUS_WAIT_STATE_EN
  localparam bit WAIT_STATES = 1'b1;
`else
  localparam bit WAIT_STATES = 1'b0;
`endif

  // Without wait states the minimum-wait count collapses to zero.
  localparam logic [3:0] WAIT_LOAD = 4'(MIN_WAIT) & {4{WAIT_STATES}};
  localparam logic [7:0] WDOG_LOAD = 8'(ACK_TIMEOUT);

  localparam int STB_IOR  = 0;
  localparam int STB_IOW  = 1;
  localparam int STB_MEMR = 2;
  localparam int STB_MEMW = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD, ST_DONE} state_t;

  logic [3:0] stb_raw;
  logic [3:0] stb_sync;
  logic [3:0] stb_fall;

  assign stb_raw = {bus.bus_memw_l, bus.bus_memr_l, bus.bus_iow_l, bus.bus_ior_l};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      logic s3_reg;

      always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
          s3_reg <= 1'b1;
        end else begin
          s1_reg <= stb_raw[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
        end
      end

      assign stb_sync[gi] = s2_reg;
      assign stb_fall[gi] = s3_reg & ~s2_reg;
    end
  endgenerate

  logic io_cs;
  logic fb_cs;

  assign io_cs = (bus.bus_a[19:IO_SPAN_LOG2] == IO_BASE_ADDR[19:IO_SPAN_LOG2]) & ~bus.bus_aen;
  assign fb_cs = (bus.bus_a[19:FB_SIZE_LOG2] == FB_ADDR[19:FB_SIZE_LOG2]);

  // IO register strobes; a write edge masks a coincident read edge.
  logic                    io_wr_hit;
  logic                    io_rd_hit;
  logic                    io_wr_stb_reg;
  logic                    io_rd_stb_reg;
  logic [IO_SPAN_LOG2-1:0] io_offset_reg;
  logic [7:0]              io_wdata_reg;

  assign io_wr_hit = stb_fall[STB_IOW] & io_cs;
  assign io_rd_hit = stb_fall[STB_IOR] & io_cs & ~io_wr_hit;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      io_wr_stb_reg <= 1'b0;
      io_rd_stb_reg <= 1'b0;
      io_offset_reg <= '0;
      io_wdata_reg  <= 8'h00;
    end else begin
      io_wr_stb_reg <= io_wr_hit;
      io_rd_stb_reg <= io_rd_hit;
      if (io_wr_hit | io_rd_hit)
        io_offset_reg <= bus.bus_a[IO_SPAN_LOG2-1:0];
      if (io_wr_hit)
        io_wdata_reg <= bus.bus_d;
    end
  end

  assign bus.io_wr_stb = io_wr_stb_reg;
  assign bus.io_rd_stb = io_rd_stb_reg;
  assign bus.io_reg    = io_offset_reg;
  assign bus.io_wdata  = io_wdata_reg;

  // Framebuffer access FSM and its datapath.
  state_t                  state_reg, state_next;
  logic                    mem_req_reg, mem_req_next;
  logic                    mem_we_reg, mem_we_next;
  logic [FB_SIZE_LOG2-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]              mem_wdata_reg, mem_wdata_next;
  logic [7:0]              rd_data_reg, rd_data_next;
  logic                    timeout_reg, timeout_next;
  logic [3:0]              wait_reg, wait_next;
  logic [7:0]              wdog_reg, wdog_next;
  logic                    mem_start;
  logic                    ack_expired;

  assign mem_start   = (stb_fall[STB_MEMR] | stb_fall[STB_MEMW]) & fb_cs;
  assign ack_expired = (wdog_reg <= 8'd1);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg     <= ST_IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 8'h00;
      rd_data_reg   <= 8'h00;
      timeout_reg   <= 1'b0;
      wait_reg      <= 4'd0;
      wdog_reg      <= 8'd0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rd_data_reg   <= rd_data_next;
      timeout_reg   <= timeout_next;
      wait_reg      <= wait_next;
      wdog_reg      <= wdog_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (mem_start) state_next = ST_REQ;
      ST_REQ:  if (bus.mem_ack || ack_expired) state_next = ST_HOLD;
      ST_HOLD: if (wait_reg == 4'd0) state_next = ST_DONE;
      // An aborted CPU cycle has already released both strobes, so this exits at once.
      ST_DONE: if (stb_sync[STB_MEMR] && stb_sync[STB_MEMW]) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rd_data_next   = rd_data_reg;
    timeout_next   = timeout_reg;
    wait_next      = wait_reg;
    wdog_next      = wdog_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem_start) begin
          mem_req_next   = 1'b1;
          mem_we_next    = stb_fall[STB_MEMW];
          mem_addr_next  = bus.bus_a[FB_SIZE_LOG2-1:0];
          mem_wdata_next = bus.bus_d;
          wait_next      = WAIT_LOAD;
          wdog_next      = WDOG_LOAD;
        end
      end
      ST_REQ: begin
        if (wait_reg != 4'd0)
          wait_next = wait_reg - 4'd1;
        if (bus.mem_ack) begin
          mem_req_next = 1'b0;
          if (!mem_we_reg)
            rd_data_next = bus.mem_rdata;
        end else if (ack_expired) begin
          mem_req_next = 1'b0;
          timeout_next = 1'b1;
          rd_data_next = 8'hFF;
          wdog_next    = 8'd0;
        end else begin
          wdog_next = wdog_reg - 8'd1;
        end
      end
      ST_HOLD: begin
        if (wait_reg != 4'd0)
          wait_next = wait_reg - 4'd1;
      end
      default: ;
    endcase
  end

  assign bus.mem_req      = mem_req_reg;
  assign bus.mem_we       = mem_we_reg;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.mem_wdata    = mem_wdata_reg;
  assign bus.timeout_flag = timeout_reg;

  // Data bus steering is combinational on the raw strobes and forced idle in reset.
  logic io_read;
  logic fb_read;

  assign io_read     = io_cs & ~bus.bus_ior_l;
  assign fb_read     = fb_cs & ~bus.bus_memr_l;
  assign bus.bus_dir = reset_l & (io_read | fb_read);

  always_comb begin
    bus.bus_out = 8'h00;
    if (reset_l) begin
      if (io_read)
        bus.bus_out = bus.io_rdata;
      else if (fb_read)
        bus.bus_out = rd_data_reg;
    end
  end

`ifdef BUS_WAIT_STATE_EN
  assign bus.bus_rdy = ~reset_l |
                       ~(fb_cs & (~bus.bus_memr_l | ~bus.bus_memw_l) & (state_reg != ST_DONE));
`else
  assign bus.bus_rdy = 1'b1;
`endif

endmodule

// File: tb/tb_isa_video_busif.sv
// Scoreboard bench for isa_video_busif: IO strobes and VRAM accesses checked against queued expectations.
module tb_isa_video_busif;

`ifdef BUS_WAIT_STATE_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  isa_video_busif_if #(.IO_SPAN_LOG2(4), .FB_SIZE_LOG2(15)) bus ();

  isa_video_busif #(
    .IO_BASE_ADDR(20'h3D0), .IO_SPAN_LOG2(4), .FB_ADDR(20'hB8000),
    .FB_SIZE_LOG2(15), .MIN_WAIT(3), .ACK_TIMEOUT(20)
  ) dut (
    .clk(clk), .reset_l(reset_l), .bus(bus)
  );

  typedef struct {bit wr; logic [3:0] rg; logic [7:0] data;} io_exp_t;
  typedef struct {bit we; logic [14:0] addr; logic [7:0] wdata;} mem_exp_t;
  io_exp_t  io_q[$];
  mem_exp_t mem_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int io_wr_cnt = 0;
  int io_rd_cnt = 0;
  int ack_cnt = 0;
  int ack_dly = 0;
  int req_age = 0;
  logic [7:0] ack_data = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pop an expectation whenever the DUT emits an IO strobe or starts a VRAM request.
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    io_exp_t  ie;
    mem_exp_t me;
    if (bus.io_wr_stb || bus.io_rd_stb) begin
      if (bus.io_wr_stb) io_wr_cnt++;
      if (bus.io_rd_stb) io_rd_cnt++;
      if (io_q.size() == 0) begin
        check_val("io_unexpected_stb", {bus.io_wr_stb, bus.io_rd_stb}, 2'b00);
      end else begin
        ie = io_q.pop_front();
        check_val("io_wr_stb", bus.io_wr_stb, ie.wr);
        check_val("io_rd_stb", bus.io_rd_stb, !ie.wr);
        check_val("io_reg", bus.io_reg, ie.rg);
        if (ie.wr) check_val("io_wdata", bus.io_wdata, ie.data);
        $display("io %s reg=%h wdata=%h", bus.io_wr_stb ? "wr" : "rd", bus.io_reg, bus.io_wdata);
      end
    end
    if (bus.mem_req && !req_prev) begin
      if (mem_q.size() == 0) begin
        check_val("mem_unexpected_req", bus.mem_req, 1'b0);
      end else begin
        me = mem_q.pop_front();
        check_val("mem_we", bus.mem_we, me.we);
        check_val("mem_addr", bus.mem_addr, me.addr);
        if (me.we) check_val("mem_wdata", bus.mem_wdata, me.wdata);
        $display("mem %s addr=%h wdata=%h", bus.mem_we ? "wr" : "rd", bus.mem_addr, bus.mem_wdata);
      end
    end
    req_prev = bus.mem_req;
  end

  // Arbiter model: one-cycle ack ack_dly cycles after mem_req rises; ack_dly 0 means never.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!bus.mem_req) req_age = 0;
      else req_age++;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req && ack_dly > 0 && req_age == ack_dly) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = ack_data;
        ack_cnt++;
      end
    end
  end

  task automatic wait_req(input string tag, input logic lvl, input int maxc, output int cyc);
    cyc = 0;
    while (bus.mem_req !== lvl && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.mem_req !== lvl) check_val({tag, "_wait_expired"}, bus.mem_req, lvl);
  endtask

  task automatic mem_begin(input bit we, input logic [19:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.bus_a = a;
    bus.bus_d = d;
    if (we) bus.bus_memw_l = 1'b0;
    else    bus.bus_memr_l = 1'b0;
  endtask

  task automatic release_all(input int settle);
    bus.bus_ior_l  = 1'b1;
    bus.bus_iow_l  = 1'b1;
    bus.bus_memr_l = 1'b1;
    bus.bus_memw_l = 1'b1;
    repeat (settle) @(negedge clk);
  endtask

  initial begin
    int c, n, w0, r0, a0;
    bus.bus_a = 20'h0; bus.bus_d = 8'h00; bus.bus_aen = 1'b0; bus.io_rdata = 8'h00;
    bus.bus_ior_l = 1'b1; bus.bus_iow_l = 1'b1; bus.bus_memr_l = 1'b1; bus.bus_memw_l = 1'b1;
    reset_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_bus_out", bus.bus_out, 8'h00);
    check_val("rst_bus_dir", bus.bus_dir, 1'b0);
    check_val("rst_bus_rdy", bus.bus_rdy, 1'b1);
    check_val("rst_io_wr_stb", bus.io_wr_stb, 1'b0);
    check_val("rst_io_rd_stb", bus.io_rd_stb, 1'b0);
    check_val("rst_io_reg", bus.io_reg, 4'h0);
    check_val("rst_io_wdata", bus.io_wdata, 8'h00);
    check_val("rst_mem_req", bus.mem_req, 1'b0);
    check_val("rst_mem_we", bus.mem_we, 1'b0);
    check_val("rst_mem_addr", bus.mem_addr, 15'h0);
    check_val("rst_mem_wdata", bus.mem_wdata, 8'h00);
    check_val("rst_timeout", bus.timeout_flag, 1'b0);
    @(negedge clk);
    reset_l = 1'b1;
    repeat (2) @(negedge clk);

    // IOW 0x3D8 held 10 cycles: one write strobe only.
    w0 = io_wr_cnt; r0 = io_rd_cnt;
    io_q.push_back('{wr: 1'b1, rg: 4'h8, data: 8'h29});
    bus.bus_a = 20'h003D8; bus.bus_d = 8'h29; bus.bus_iow_l = 1'b0;
    repeat (10) @(negedge clk);
    check_val("iow_bus_dir", bus.bus_dir, 1'b0);
    release_all(5);
    check_val("iow_wr_count", io_wr_cnt - w0, 1);
    check_val("iow_rd_count", io_rd_cnt - r0, 0);

    // IOR 0x3DA drives status byte; repeated with AEN set it is ignored.
    r0 = io_rd_cnt;
    io_q.push_back('{wr: 1'b0, rg: 4'hA, data: 8'h00});
    bus.io_rdata = 8'hF9; bus.bus_a = 20'h003DA; bus.bus_ior_l = 1'b0;
    repeat (5) @(negedge clk);
    check_val("ior_bus_dir", bus.bus_dir, 1'b1);
    check_val("ior_bus_out", bus.bus_out, 8'hF9);
    release_all(5);
    check_val("ior_rd_count", io_rd_cnt - r0, 1);
    r0 = io_rd_cnt;
    bus.bus_aen = 1'b1; bus.bus_ior_l = 1'b0;
    repeat (5) @(negedge clk);
    check_val("ior_aen_bus_dir", bus.bus_dir, 1'b0);
    check_val("ior_aen_bus_out", bus.bus_out, 8'h00);
    release_all(5);
    bus.bus_aen = 1'b0;
    check_val("ior_aen_rd_count", io_rd_cnt - r0, 0);

    // Simultaneous IOR/IOW edges take the write; an out-of-window write is ignored.
    w0 = io_wr_cnt; r0 = io_rd_cnt;
    io_q.push_back('{wr: 1'b1, rg: 4'h3, data: 8'h11});
    bus.bus_a = 20'h003D3; bus.bus_d = 8'h11; bus.bus_iow_l = 1'b0; bus.bus_ior_l = 1'b0;
    repeat (6) @(negedge clk);
    release_all(5);
    bus.bus_a = 20'h003C8; bus.bus_iow_l = 1'b0;
    repeat (6) @(negedge clk);
    release_all(5);
    check_val("both_wr_count", io_wr_cnt - w0, 1);
    check_val("both_rd_count", io_rd_cnt - r0, 0);

    // MEMW 0xB8123, ack after 6 cycles.
    ack_dly = 6; a0 = ack_cnt;
    mem_q.push_back('{we: 1'b1, addr: 15'h0123, wdata: 8'h5A});
    mem_begin(1'b1, 20'hB8123, 8'h5A);
    #1 check_val("memw_rdy_fall", bus.bus_rdy, !WAIT_EN);
    wait_req("memw_rise", 1'b1, 10, c);
    check_val("memw_rdy_in_req", bus.bus_rdy, !WAIT_EN);
    wait_req("memw_fall", 1'b0, 40, c);
    check_val("memw_req_cycles", c, 6);
    check_val("memw_ack_count", ack_cnt - a0, 1);
    repeat (6) @(negedge clk);
    check_val("memw_rdy_done", bus.bus_rdy, 1'b1);
    release_all(4);

    // MEMR 0xBFFFF, early ack: wait states still stretch the cycle.
    ack_dly = 1; ack_data = 8'hC3;
    mem_q.push_back('{we: 1'b0, addr: 15'h7FFF, wdata: 8'h00});
    mem_begin(1'b0, 20'hBFFFF, 8'h00);
    wait_req("memr_rise", 1'b1, 10, c);
    n = 0;
    while (bus.bus_rdy == 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_val("memr_min_wait", (n >= 3), WAIT_EN);
    repeat (6) @(negedge clk);
    check_val("memr_bus_out", bus.bus_out, 8'hC3);
    check_val("memr_bus_dir", bus.bus_dir, 1'b1);
    release_all(4);
    check_val("memr_out_idle", bus.bus_out, 8'h00);

    // MEMR 0xB8000 with no ack: watchdog fires after 20 cycles.
    ack_dly = 0;
    check_val("wdog_flag_before", bus.timeout_flag, 1'b0);
    mem_q.push_back('{we: 1'b0, addr: 15'h0000, wdata: 8'h00});
    mem_begin(1'b0, 20'hB8000, 8'h00);
    wait_req("wdog_rise", 1'b1, 10, c);
    wait_req("wdog_fall", 1'b0, 60, c);
    check_val("wdog_req_cycles", c, 20);
    repeat (6) @(negedge clk);
    check_val("wdog_flag", bus.timeout_flag, 1'b1);
    check_val("wdog_bus_out", bus.bus_out, 8'hFF);
    check_val("wdog_rdy", bus.bus_rdy, 1'b1);
    release_all(4);

    // CPU aborts mid-request; the next read must still be served.
    ack_dly = 5; ack_data = 8'h3C;
    mem_q.push_back('{we: 1'b1, addr: 15'h0010, wdata: 8'h66});
    mem_begin(1'b1, 20'hB8010, 8'h66);
    wait_req("abort_rise", 1'b1, 10, c);
    @(negedge clk);
    release_all(0);
    wait_req("abort_fall", 1'b0, 40, c);
    check_val("abort_req_cycles", c, 4);
    repeat (8) @(negedge clk);
    ack_dly = 2;
    mem_q.push_back('{we: 1'b0, addr: 15'h0020, wdata: 8'h00});
    mem_begin(1'b0, 20'hB8020, 8'h00);
    wait_req("after_abort_rise", 1'b1, 10, c);
    wait_req("after_abort_fall", 1'b0, 20, c);
    repeat (6) @(negedge clk);
    check_val("after_abort_bus_out", bus.bus_out, 8'h3C);
    release_all(4);

    // Reset pulsed during REQ, then a normal write.
    ack_dly = 0;
    mem_q.push_back('{we: 1'b1, addr: 15'h0456, wdata: 8'h77});
    mem_begin(1'b1, 20'hB8456, 8'h77);
    wait_req("rst_rise", 1'b1, 10, c);
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    check_val("rst_mid_mem_req", bus.mem_req, 1'b0);
    check_val("rst_mid_rdy", bus.bus_rdy, 1'b1);
    check_val("rst_mid_timeout", bus.timeout_flag, 1'b0);
    release_all(2);
    reset_l = 1'b1;
    repeat (2) @(negedge clk);
    ack_dly = 3; a0 = ack_cnt;
    mem_q.push_back('{we: 1'b1, addr: 15'h0456, wdata: 8'hA5});
    mem_begin(1'b1, 20'hB8456, 8'hA5);
    wait_req("post_rst_rise", 1'b1, 10, c);
    wait_req("post_rst_fall", 1'b0, 40, c);
    check_val("post_rst_req_cycles", c, 3);
    check_val("post_rst_ack_count", ack_cnt - a0, 1);
    repeat (6) @(negedge clk);
    check_val("post_rst_rdy", bus.bus_rdy, 1'b1);
    release_all(4);
    check_val("post_rst_timeout", bus.timeout_flag, 1'b0);

    check_val("io_queue_left", io_q.size(), 0);
    check_val("mem_queue_left", mem_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/isa_video_busif.md
Name: isa_video_busif

Overview:
Parametrised ISA-bus front end for video cards. It generalises the fixed CGA/HGC decode into a block with a configurable IO window and framebuffer window.
- Synchronises the bus strobes and emits exactly one single-cycle register strobe per IO cycle.
- Runs a request/acknowledge handshake to the VRAM arbiter, with programmable ISA wait states and a watchdog.
- Sits between the ISA pins and the card core (register file, CRTC, VRAM arbiter).

Parameters:
IO_BASE_ADDR, 20'h3D0, base of IO window; must be aligned to 2^IO_SPAN_LOG2.
IO_SPAN_LOG2, 4, log2 of IO window size; 16 ports by default.
FB_ADDR, 20'hB8000, framebuffer base; must be aligned to 2^FB_SIZE_LOG2.
FB_SIZE_LOG2, 15, log2 of framebuffer window in bytes (32 KB).
MIN_WAIT, 3, minimum clk cycles bus_rdy is held low per memory cycle; range 0..15.
ACK_TIMEOUT, 255, clk cycles to wait for mem_ack before forced release; range 1..255.

Ports:
clk  in  1  system clock
reset_l  in  1  asynchronous active-low reset
bus_a  in  20  ISA address
bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l  in  1 each  ISA strobes, active low
bus_aen  in  1  DMA address enable; IO decode qualified by ~bus_aen
bus_d  in  8  ISA write data
bus_out  out  8  ISA read data
bus_dir  out  1  1 = card drives data bus
bus_rdy  out  1  ISA IOCHRDY; 0 = insert wait
io_reg  out  IO_SPAN_LOG2  register offset within IO window, held for the cycle
io_wr_stb  out  1  one-cycle write strobe
io_rd_stb  out  1  one-cycle read strobe; for side effects, e.g. status read
io_wdata  out  8  bus_d captured at the strobe
io_rdata  in  8  register read data, combinational from core
mem_req  out  1  VRAM access request
mem_we  out  1  1 = write
mem_addr  out  FB_SIZE_LOG2  framebuffer byte offset
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid with mem_ack
mem_ack  in  1  one-cycle acknowledge from arbiter
timeout_flag  out  1  sticky; set on watchdog expiry, cleared by reset only

Behaviour:
- Reset values: bus_out=0, bus_dir=0, bus_rdy=1, io_wr_stb=0, io_rd_stb=0, io_reg=0, io_wdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout_flag=0. FSM enters IDLE; all synchronisers are loaded with 1 (inactive).
- Synchronisers: each strobe passes through a 2-flop synchroniser, then a falling-edge detector. An assertion is recognised 3 clk after the pin falls.
- IO decode: io_cs = bus_a[19:IO_SPAN_LOG2]==IO_BASE_ADDR[19:IO_SPAN_LOG2] & ~bus_aen.
- IO write edge with io_cs: one-cycle io_wr_stb; io_reg and io_wdata are registered in the same cycle.
- IO read edge with io_cs: one-cycle io_rd_stb.
- A strobe held low for any length produces exactly one pulse. A new pulse needs a deassert then reassert.
- Simultaneous IOR and IOW edges: the write is taken, the read is ignored.
- bus_dir=1 combinationally while (io_cs & ~bus_ior_l) or (fb_cs & ~bus_memr_l).
- bus_out=io_rdata during IO read; bus_out=latched mem read byte during mem read; otherwise 0.
- Memory decode: fb_cs = bus_a[19:FB_SIZE_LOG2]==FB_ADDR[19:FB_SIZE_LOG2]; not qualified by aen.
- FSM states: IDLE, REQ, HOLD, DONE.
  - IDLE -> REQ on a synced MEMR or MEMW edge with fb_cs. Latch mem_addr=bus_a[FB_SIZE_LOG2-1:0], mem_we, mem_wdata; assert mem_req; load wait counter=MIN_WAIT and watchdog=ACK_TIMEOUT.
  - REQ: mem_req held high until mem_ack. On ack: drop mem_req next cycle, latch mem_rdata if a read, go to HOLD. Watchdog decrements each cycle; at 0 drop mem_req, set timeout_flag, latch 8'hFF as read data, go to HOLD.
  - HOLD: count down the remaining wait counter (it runs from REQ entry); at 0 -> DONE.
  - DONE: stay until both synced MEMR and MEMW are high, then -> IDLE.
- bus_rdy is combinational: 0 while fb_cs & (~bus_memr_l | ~bus_memw_l) & state!=DONE; else 1. It drops in the same cycle the raw strobe falls.
- A strobe released mid-REQ (CPU aborts) does not cancel the request. The access completes and the FSM returns to IDLE without entering a stuck DONE.
- reset_l asserted mid-operation returns everything to reset values asynchronously. An arbiter that has seen mem_req must tolerate its loss.
- Counters saturate at 0; there is no wrap-around.

Optional Feature:
BUS_WAIT_STATE_EN.
- Defined: bus_rdy behaves as above.
- Undefined: bus_rdy is constant 1, MIN_WAIT is ignored, and HOLD goes straight to DONE. A CPU memory read then returns the previous access's latched byte; this is accepted, as the no-wait CGA mode already works this way.
- The watchdog and timeout_flag exist in both builds.

Test Plan:
1. IOW to 0x3D8 data 8'h29, pin low 10 clk -> exactly one io_wr_stb; io_reg=4'h8, io_wdata=8'h29; no io_rd_stb.
2. IOR 0x3DA with io_rdata=8'hF9 -> bus_dir=1, bus_out=8'hF9, exactly one io_rd_stb. Same access with bus_aen=1 -> no strobe, bus_dir=0.
3. MEMW 0xB8123 data 8'h5A, arbiter acks after 6 clk -> mem_addr=15'h0123, mem_we=1, mem_wdata=8'h5A, single ack consumed; bus_rdy low from strobe fall until DONE; bus_rdy then 1 (EN build).
4. MEMR 0xBFFFF, ack after 1 clk with mem_rdata=8'hC3, MIN_WAIT=3 -> mem_addr=15'h7FFF; bus_rdy stays low ≥3 clk after REQ entry despite the early ack; bus_out=8'hC3.
5. MEMR 0xB8000, mem_ack never asserted, ACK_TIMEOUT=20 -> mem_req drops after 20 clk, timeout_flag=1, bus_out=8'hFF, bus_rdy releases.
6. reset_l pulsed low during REQ -> mem_req=0 and bus_rdy=1 immediately; next MEMW after reset completes normally.
